// File: rtl/pumpeds_pkg.sv
// rtl/pumpeds_pkg.sv - shared state encoding and default width for the result skid buffer
package pumpeds_pkg;

  localparam int DEFAULT_BIT_WIDTH = 32;

  typedef enum logic [1:0] {
    RS_EMPTY = 2'd0,
    RS_ONE   = 2'd1,
    RS_TWO   = 2'd2
  } rs_state_e;

endpackage

// File: rtl/res_skid_if.sv
// rtl/res_skid_if.sv - result handshake bundle between execute stage, skid buffer and resizer mux
interface res_skid_if #(
  parameter int BIT_WIDTH = pumpeds_pkg::DEFAULT_BIT_WIDTH
);

  logic                 In_valid;
  logic [BIT_WIDTH-1:0] In_data;
  logic                 In_ready;
  logic                 Out_ready;
  logic                 Flush;
  logic [BIT_WIDTH-1:0] Res_line;
  logic                 Disable;
  logic [1:0]           Count;

  // Producer/consumer side: drives the result stream and consumer handshake
  modport master (
    output In_valid, In_data, Out_ready, Flush,
    input  In_ready, Res_line, Disable, Count
  );

  // Buffer side
  modport slave (
    input  In_valid, In_data, Out_ready, Flush,
    output In_ready, Res_line, Disable, Count
  );

endinterface

// File: rtl/res_reg.sv
// rtl/res_reg.sv - data register with load enable, synchronous clear and async active-low reset
module res_reg #(
  parameter int BIT_WIDTH = pumpeds_pkg::DEFAULT_BIT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 load,
  input  logic [BIT_WIDTH-1:0] d,
  output logic [BIT_WIDTH-1:0] q
);

  logic [BIT_WIDTH-1:0] data_d;
  logic [BIT_WIDTH-1:0] data_q;

  // Clear wins over load so a flush can never leave a freshly loaded value behind
  always_comb begin
    data_d = data_q;
    if (clr) begin
      data_d = '0;
    end else if (load) begin
      data_d = d;
    end
  end

  // Entry storage
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign q = data_q;

endmodule

// File: rtl/res_skid.sv
// rtl/res_skid.sv - two-entry registered skid buffer feeding the result-line resizer/disable mux
module res_skid
  import pumpeds_pkg::*;
#(
  parameter int    UUID      = 0,
  parameter string NAME      = "",
  parameter int    BIT_WIDTH = DEFAULT_BIT_WIDTH
) (
  input  logic        clk,
  input  logic        rst,
  res_skid_if.slave   bus
);

  rs_state_e            state_d, state_q;
  logic                 in_ready_q;
  logic                 disable_q;
  logic [1:0]           count_q;

  logic                 push, pop;
  logic                 clr;
  logic                 a_load, b_load;
  logic [BIT_WIDTH-1:0] a_din;
  logic [BIT_WIDTH-1:0] a_q, b_q;

  // Handshakes only look at registered flags, so no input reaches In_ready combinationally
  assign push = bus.In_valid & in_ready_q;
  assign pop  = bus.Out_ready & ~disable_q;

  // Next state and entry load control; A always holds the oldest result
  always_comb begin
    state_d = state_q;
    clr     = 1'b0;
    a_load  = 1'b0;
    b_load  = 1'b0;
    a_din   = bus.In_data;
    if (bus.Flush) begin
      state_d = RS_EMPTY;
      clr     = 1'b1;
    end else begin
      unique case (state_q)
        RS_EMPTY: begin
          if (push) begin
            state_d = RS_ONE;
            a_load  = 1'b1;
          end
        end
        RS_ONE: begin
          if (push && !pop) begin
            state_d = RS_TWO;
            b_load  = 1'b1;
          end else if (pop && !push) begin
            state_d = RS_EMPTY;
          end else if (push && pop) begin
            a_load  = 1'b1;
          end
        end
        RS_TWO: begin
          if (pop) begin
            state_d = RS_ONE;
            a_load  = 1'b1;
            a_din   = b_q;
          end
        end
        default: begin
          state_d = RS_EMPTY;
          clr     = 1'b1;
        end
      endcase
    end
  end

  // State register with outputs registered alongside it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= RS_EMPTY;
      count_q    <= 2'd0;
      disable_q  <= 1'b1;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      count_q    <= state_d;
      disable_q  <= (state_d == RS_EMPTY);
      in_ready_q <= (state_d != RS_TWO);
    end
  end

  res_reg #(.BIT_WIDTH(BIT_WIDTH)) u_entry_a (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr),
    .load (a_load),
    .d    (a_din),
    .q    (a_q)
  );

  res_reg #(.BIT_WIDTH(BIT_WIDTH)) u_entry_b (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr),
    .load (b_load),
    .d    (bus.In_data),
    .q    (b_q)
  );

  assign bus.Res_line = disable_q ? '0 : a_q;
  assign bus.Disable  = disable_q;
  assign bus.In_ready = in_ready_q;
  assign bus.Count    = count_q;

endmodule

// File: tb/tb_res_skid.sv
// tb/tb_res_skid.sv - scoreboard bench for the result skid buffer
module tb_res_skid;

  logic clk;
  logic rst;

  res_skid_if #(.BIT_WIDTH(32)) bus ();

  res_skid #(.UUID(0), .NAME("tb"), .BIT_WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string name);
    check({name, "_count"},    32'(bus.Count),    32'd0);
    check({name, "_disable"},  32'(bus.Disable),  32'd1);
    check({name, "_res_line"}, bus.Res_line,      32'd0);
    check({name, "_in_ready"}, 32'(bus.In_ready), 32'd1);
  endtask

  task automatic push_vec(input logic [31:0] v);
    bus.In_valid = 1'b1;
    bus.In_data  = v;
    exp_q.push_back(v);
  endtask

  // Monitor: every consumed result must be the oldest expected one
  always @(negedge clk) begin
    if (rst && bus.Out_ready && !bus.Disable) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL pop_unexpected: got 0x%08h expected no data", bus.Res_line);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (bus.Res_line !== e) begin
          n_fail++;
          $display("FAIL pop_order: got 0x%08h expected 0x%08h", bus.Res_line, e);
        end
      end
    end
  end

  initial begin
    rst           = 1'b0;
    bus.In_valid  = 1'b0;
    bus.In_data   = '0;
    bus.Out_ready = 1'b0;
    bus.Flush     = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check_idle("reset_held");
    rst = 1'b1;
    cyc();
    check_idle("reset_released");

    push_vec(32'hDEADBEEF);
    cyc();
    check("push1_res_line", bus.Res_line, 32'hDEADBEEF);
    check("push1_disable", 32'(bus.Disable), 32'd0);
    check("push1_count", 32'(bus.Count), 32'd1);
    push_vec(32'h12345678);
    cyc();
    check("push2_count", 32'(bus.Count), 32'd2);
    check("push2_in_ready", 32'(bus.In_ready), 32'd0);
    check("push2_res_line", bus.Res_line, 32'hDEADBEEF);

    bus.In_valid  = 1'b0;
    bus.Out_ready = 1'b1;
    cyc();
    check("pop1_in_ready", 32'(bus.In_ready), 32'd1);
    check("pop1_count", 32'(bus.Count), 32'd1);
    check("pop1_res_line", bus.Res_line, 32'h12345678);
    cyc();
    check_idle("pop2");
    bus.Out_ready = 1'b0;

    for (int i = 1; i <= 10; i++) begin
      push_vec(32'(i));
      bus.Out_ready = 1'b1;
      cyc();
      check("stream_res_line", bus.Res_line, 32'(i));
      check("stream_count", 32'(bus.Count), 32'd1);
    end
    bus.In_valid = 1'b0;
    cyc();
    check_idle("stream_drained");
    bus.Out_ready = 1'b0;

    push_vec(32'h00000011);
    cyc();
    push_vec(32'h00000022);
    cyc();
    check("preflush_count", 32'(bus.Count), 32'd2);
    exp_q.delete();
    bus.Flush    = 1'b1;
    bus.In_valid = 1'b1;
    bus.In_data  = 32'hAAAA0000;
    cyc();
    check_idle("flush");
    bus.Flush     = 1'b0;
    bus.In_valid  = 1'b0;
    bus.Out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      check_idle("empty_pop");
    end
    bus.Out_ready = 1'b0;

    push_vec(32'h00000055);
    cyc();
    push_vec(32'h00000066);
    cyc();
    bus.In_valid = 1'b0;
    check("prereset_count", 32'(bus.Count), 32'd2);
    #2;
    rst = 1'b0;
    #1;
    check_idle("async_reset");
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b1;
    cyc();
    check_idle("after_async_reset");

    push_vec(32'h00000077);
    cyc();
    check("post_reset_res_line", bus.Res_line, 32'h00000077);
    bus.In_valid  = 1'b0;
    bus.Out_ready = 1'b1;
    cyc();
    check_idle("post_reset_drain");
    bus.Out_ready = 1'b0;
    cyc();

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
